// File: rtl/seq_fsm_p2.sv
// Sequence detector for the serial pattern 1-1-0-1, with a timed DET hold and a re-arm gate.
// Define SEQ_FSM_SYNC_W_EN to pass w through a 2-flop synchronizer (adds 2 cycles of latency).
module seq_fsm_p2 #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             w,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             det_pulse
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        S1    = 3'b001,
        S11   = 3'b011,
        S110  = 3'b110,
        DET   = 3'b010,
        REARM = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_det_pulse;
    logic             w_w;

`ifdef SEQ_FSM_SYNC_W_EN
    logic r_w_s1;
    logic r_w_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_w_s1 <= 1'b0;
            r_w_s2 <= 1'b0;
        end else begin
            r_w_s1 <= w;
            r_w_s2 <= r_w_s1;
        end
    end

    assign w_w = r_w_s2;
`else
    assign w_w = w;
`endif

    always_comb begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
        case (r_state)
            IDLE:  w_state_nxt = w_w ? S1    : IDLE;
            S1:    w_state_nxt = w_w ? S11   : IDLE;
            S11:   w_state_nxt = w_w ? S11   : S110;
            S110:  w_state_nxt = w_w ? DET   : IDLE;
            REARM: w_state_nxt = w_w ? REARM : IDLE;
            DET: begin
                // Exit takes the edge that would otherwise increment, so the counter never wraps.
                if (r_count == TERM) begin
                    w_state_nxt = REARM;
                end else begin
                    w_state_nxt = DET;
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_det_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_det_pulse <= (w_state_nxt == DET) && (r_state != DET);
        end
    end

    assign state     = r_state;
    assign count     = r_count;
    assign det_pulse = r_det_pulse;

endmodule

// File: tb/tb_seq_fsm_p2.sv
// Directed bench for seq_fsm_p2 in its default build (HOLD_CYCLES=8, CNT_W=4, synchronizer off).
module tb_seq_fsm_p2;

    logic       clk;
    logic       resetn;
    logic       w;
    logic [2:0] state;
    logic [3:0] count;
    logic       det_pulse;

    int checks;
    int failures;

    seq_fsm_p2 #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .w         (w),
        .state     (state),
        .count     (count),
        .det_pulse (det_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] es, input logic [3:0] ec, input logic ep);
        checks++;
        assert (state === es) else begin
            failures++;
            $error("FAIL %s state observed=%b expected=%b", tag, state, es);
        end
        checks++;
        assert (count === ec) else begin
            failures++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, count, ec);
        end
        checks++;
        assert (det_pulse === ep) else begin
            failures++;
            $error("FAIL %s det_pulse observed=%b expected=%b", tag, det_pulse, ep);
        end
    endtask

    // Drive w, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic wv);
        w = wv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        w        = 1'b0;

        // Held in reset while w toggles.
        for (int i = 0; i < 4; i++) begin
            step(i[0] ? 1'b0 : 1'b1);
            chk("reset_hold", 3'b000, 4'd0, 1'b0);
        end
        resetn = 1'b1;
        w      = 1'b0;

        // Basic detect 1,1,0,1 then w=0.
        step(1'b1); chk("basic_s1",   3'b001, 4'd0, 1'b0);
        step(1'b1); chk("basic_s11",  3'b011, 4'd0, 1'b0);
        step(1'b0); chk("basic_s110", 3'b110, 4'd0, 1'b0);
        step(1'b1); chk("basic_det0", 3'b010, 4'd0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step(1'b0); chk("basic_det", 3'b010, 4'(i), 1'b0);
        end
        step(1'b0); chk("basic_rearm", 3'b100, 4'd0, 1'b0);
        step(1'b0); chk("basic_idle",  3'b000, 4'd0, 1'b0);

        // Overlap: 1,1,1,1,0,1 holds S11 then detects; w held high through DET and 5 REARM cycles.
        step(1'b1); chk("ovl_s1",  3'b001, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1); chk("ovl_s11", 3'b011, 4'd0, 1'b0);
        end
        step(1'b0); chk("ovl_s110", 3'b110, 4'd0, 1'b0);
        step(1'b1); chk("ovl_det0", 3'b010, 4'd0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step(1'b1); chk("ovl_det", 3'b010, 4'(i), 1'b0);
        end
        step(1'b1); chk("gate_rearm", 3'b100, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1); chk("gate_hold", 3'b100, 4'd0, 1'b0);
        end
        step(1'b0); chk("gate_idle", 3'b000, 4'd0, 1'b0);

        // Partial 1,1,0,0 falls back to IDLE without a pulse.
        step(1'b1); chk("part_s1",   3'b001, 4'd0, 1'b0);
        step(1'b1); chk("part_s11",  3'b011, 4'd0, 1'b0);
        step(1'b0); chk("part_s110", 3'b110, 4'd0, 1'b0);
        step(1'b0); chk("part_idle", 3'b000, 4'd0, 1'b0);

        // Reset asserted mid-cycle at count=3 in DET.
        step(1'b1); step(1'b1); step(1'b0);
        step(1'b1); chk("mid_det0", 3'b010, 4'd0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step(1'b0); chk("mid_det", 3'b010, 4'(i), 1'b0);
        end
        #2 resetn = 1'b0;
        #1 chk("async_rst", 3'b000, 4'd0, 1'b0);
        step(1'b1); chk("async_rst_hold", 3'b000, 4'd0, 1'b0);
        resetn = 1'b1;
        step(1'b1); chk("post_s1",   3'b001, 4'd0, 1'b0);
        step(1'b1); chk("post_s11",  3'b011, 4'd0, 1'b0);
        step(1'b0); chk("post_s110", 3'b110, 4'd0, 1'b0);
        step(1'b1); chk("post_det0", 3'b010, 4'd0, 1'b1);
        step(1'b0); chk("post_det1", 3'b010, 4'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
